// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester arbiter sharing one 32-bit ALU; IDLE/EXEC/RESP FSM
//            with round-robin or fixed-priority grant and a held response.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
    parameter int RR_EN = 1,
    parameter int OPW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic [OPW-1:0]  req0_op,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    input  logic [OPW-1:0]  req1_op,
    output logic            req1_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [31:0]     rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] C_OP_ADD = 3'b010;
    localparam logic [OPW-1:0] C_OP_SUB = 3'b110;
    localparam logic [OPW-1:0] C_OP_AND = 3'b000;
    localparam logic [OPW-1:0] C_OP_OR  = 3'b001;
    localparam logic [OPW-1:0] C_OP_SLT = 3'b111;
    localparam logic [OPW-1:0] C_OP_BEQ = 3'b100;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prio;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [OPW-1:0]  r_op;
    logic            r_id;

    logic            w_grant_id;
    logic            w_accept;
    logic [31:0]     w_alu_result;
    logic            w_alu_zero;
    logic            w_alu_err;

    // Grant selection; reset suppresses any acceptance in the same cycle.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant_id = (RR_EN != 0) ? r_prio : 1'b0;
        end else begin
            w_grant_id = req1_valid;
        end
        w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid) && !reset;
        req0_ready = w_accept && !w_grant_id;
        req1_ready = w_accept &&  w_grant_id;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_EXEC;
            S_EXEC:                 w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // BEQ reports a+b as its result; its zero flag carries the unsigned a<b test.
    always_comb begin
        w_alu_result = 32'd0;
        w_alu_zero   = 1'b0;
        w_alu_err    = 1'b0;
        case (r_op)
            C_OP_ADD: w_alu_result = r_a + r_b;
            C_OP_SUB: w_alu_result = r_a - r_b;
            C_OP_AND: w_alu_result = r_a & r_b;
            C_OP_OR:  w_alu_result = r_a | r_b;
            C_OP_SLT: w_alu_result = {31'd0, (r_a < r_b)};
            C_OP_BEQ: begin
                w_alu_result = r_a + r_b;
                w_alu_zero   = (r_a < r_b);
            end
            default:  w_alu_err = 1'b1;
        endcase
    end

    assign rsp_valid = (r_state == S_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prio     <= 1'b0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_op       <= '0;
            r_id       <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a    <= w_grant_id ? req1_a  : req0_a;
                r_b    <= w_grant_id ? req1_b  : req0_b;
                r_op   <= w_grant_id ? req1_op : req0_op;
                r_id   <= w_grant_id;
                r_prio <= ~w_grant_id;
            end
            if (r_state == S_EXEC) begin
                rsp_id     <= r_id;
                rsp_result <= w_alu_result;
                rsp_zero   <= w_alu_zero;
                rsp_err    <= w_alu_err;
            end
        end
    end

endmodule
`default_nettype wire
